// File: rtl/regfile_pkg.sv
// Shared register-file definitions: state encoding and default datapath widths
// used by decode, writeback and the register file itself.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: writeback port, packed read addresses/data and ready.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
);

  logic                     regWrite;
  logic [ADDR_W-1:0]        address;
  logic [DATA_W-1:0]        data;
  logic [NUM_RD*ADDR_W-1:0] readRegister;
  logic [NUM_RD*DATA_W-1:0] readData;
  logic                     ready;

  modport master (
    output regWrite, address, data, readRegister,
    input  readData, ready
  );

  modport slave (
    input  regWrite, address, data, readRegister,
    output readData, ready
  );

endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-register check, write-first bypass, array mux.
module regfile_rd_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] entry,
  output logic [DATA_W-1:0] rdata
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      rdata <= '0;
    end else if ((ZERO_REG != 0) && (raddr == '0)) begin
      rdata <= '0;
    end else if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= entry;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a one-entry-per-cycle clear sweep on reset.
//
// state    | meaning
// ST_CLEAR | sweeping zeros into entry[ptr], writes ignored, reads return 0
// ST_RUN   | array initialised, writes accepted, ready high
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     ptr_q, ptr_d;
  logic                  ready_q;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic                  wr_drop;
  logic                  we_run;
  logic                  clr;
  logic [NUM_RD*DATA_W-1:0] rd_all;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= (state_d == ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN:   state_d = ST_RUN;
      default:  state_d = ST_CLEAR;
    endcase
  end

  assign clr     = (state_q == ST_CLEAR);
  assign wr_drop = (ZERO_REG != 0) && (bus.address == '0);
  assign we_run  = bus.regWrite && !clr && !wr_drop && !reset;

  // Single write port with no reset on the storage, so the array can map to RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr) begin
        mem[ptr_q] <= '0;
      end else if (we_run) begin
        mem[bus.address] <= bus.data;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    assign raddr = bus.readRegister[i*ADDR_W +: ADDR_W];

    regfile_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .we    (we_run),
      .waddr (bus.address),
      .wdata (bus.data),
      .raddr (raddr),
      .entry (mem[raddr]),
      .rdata (rd_all[i*DATA_W +: DATA_W])
    );
  end

  assign bus.readData = rd_all;
  assign bus.ready    = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three configurations share one clock.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset_a, reset_b, reset_c;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_a ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if_b ();
  regfile_mp_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) if_c ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset_a), .bus(if_a.slave));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset_b), .bus(if_b.slave));
  regfile_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) dut_c (
    .clk(clk), .reset(reset_c), .bus(if_c.slave));

  // kind 0 = readData port, kind 1 = ready
  typedef struct {
    int          dut;
    int          stamp;
    int          kind;
    int          port;
    logic [63:0] exp;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  task automatic push(int dut, int kind, int port, logic [63:0] v, int tag);
    exp_t e;
    e.dut = dut; e.stamp = cyc + 1; e.kind = kind;
    e.port = port; e.exp = v; e.tag = tag;
    sbq.push_back(e);
  endtask

  function automatic logic [63:0] actual(int dut, int kind, int port);
    logic [63:0] v;
    v = '0;
    case (dut)
      0: v = (kind == 1) ? 64'(if_a.ready) : 64'(if_a.readData[port*32 +: 32]);
      1: v = (kind == 1) ? 64'(if_b.ready) : 64'(if_b.readData[port*32 +: 32]);
      default: v = (kind == 1) ? 64'(if_c.ready) : if_c.readData[port*64 +: 64];
    endcase
    return v;
  endfunction

  initial begin : monitor
    exp_t keep[$];
    logic [63:0] act;
    forever begin
      @(negedge clk);
      #1;
      keep.delete();
      foreach (sbq[i]) begin
        if (sbq[i].stamp == cyc) begin
          act = actual(sbq[i].dut, sbq[i].kind, sbq[i].port);
          checks++;
          if (act !== sbq[i].exp) begin
            errors++;
            $display("FAIL %s dut%0d port%0d tag%0d cyc%0d: got %h, expected %h",
                     (sbq[i].kind == 1) ? "ready" : "readData", sbq[i].dut,
                     sbq[i].port, sbq[i].tag, cyc, act, sbq[i].exp);
          end
        end else if (sbq[i].stamp < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed dut%0d tag%0d: stamp %0d, now %0d",
                   sbq[i].dut, sbq[i].tag, sbq[i].stamp, cyc);
        end else begin
          keep.push_back(sbq[i]);
        end
      end
      sbq = keep;
    end
  end

  task automatic drv_a(bit r, bit we, logic [4:0] wa, logic [31:0] wd,
                       logic [4:0] ra0, logic [4:0] ra1);
    reset_a = r; if_a.regWrite = we; if_a.address = wa; if_a.data = wd;
    if_a.readRegister = {ra1, ra0};
    @(negedge clk);
  endtask

  task automatic drv_b(bit r, bit we, logic [4:0] wa, logic [31:0] wd,
                       logic [4:0] ra0, logic [4:0] ra1);
    reset_b = r; if_b.regWrite = we; if_b.address = wa; if_b.data = wd;
    if_b.readRegister = {ra1, ra0};
    @(negedge clk);
  endtask

  task automatic drv_c(bit r, bit we, logic [3:0] wa, logic [63:0] wd,
                       logic [3:0] ra0, logic [3:0] ra1, logic [3:0] ra2, logic [3:0] ra3);
    reset_c = r; if_c.regWrite = we; if_c.address = wa; if_c.data = wd;
    if_c.readRegister = {ra3, ra2, ra1, ra0};
    @(negedge clk);
  endtask

  // Reset pulse of one cycle: ready low on the reset edge plus DEPTH-1 sweep edges,
  // high on the edge that writes the last entry.
  task automatic sweep_a(int tag);
    push(0, 1, 0, 64'd0, tag);
    drv_a(1, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int k = 1; k <= 32; k++) begin
      push(0, 1, 0, 64'(k == 32), tag);
      drv_a(0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    end
  endtask

  task automatic sweep_b(int tag);
    push(1, 1, 0, 64'd0, tag);
    drv_b(1, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int k = 1; k <= 32; k++) begin
      push(1, 1, 0, 64'(k == 32), tag);
      drv_b(0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    end
  endtask

  task automatic sweep_c(int tag);
    push(2, 1, 0, 64'd0, tag);
    drv_c(1, 0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    for (int k = 1; k <= 16; k++) begin
      push(2, 1, 0, 64'(k == 16), tag);
      drv_c(0, 0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  logic [63:0] cval [1:4];

  initial begin : stim
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    if_a.regWrite = 1'b0; if_a.address = '0; if_a.data = '0; if_a.readRegister = '0;
    if_b.regWrite = 1'b0; if_b.address = '0; if_b.data = '0; if_b.readRegister = '0;
    if_c.regWrite = 1'b0; if_c.address = '0; if_c.data = '0; if_c.readRegister = '0;
    @(negedge clk);

    // DUT A: initial sweep, fill with garbage, confirm it landed
    sweep_a(1);
    for (int i = 0; i < 32; i++)
      drv_a(0, 1, 5'(i), 32'hA5A50000 | i, 5'd0, 5'd0);
    push(0, 0, 0, 64'hA5A50007, 2);
    push(0, 0, 1, 64'hA5A5001F, 2);
    drv_a(0, 0, 5'd0, 32'd0, 5'd7, 5'd31);

    // Reset sweep clears every entry
    sweep_a(3);
    for (int i = 0; i < 32; i++) begin
      push(0, 0, 0, 64'd0, 4);
      push(0, 0, 1, 64'd0, 4);
      drv_a(0, 0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
    end

    // Write then read
    drv_a(0, 1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd0);
    push(0, 0, 0, 64'hDEADBEEF, 5);
    push(0, 0, 1, 64'd0, 5);
    drv_a(0, 0, 5'd0, 32'd0, 5'd7, 5'd3);

    // Bypass, then plain read of the same register
    push(0, 0, 0, 64'h12345678, 6);
    push(0, 0, 1, 64'h12345678, 6);
    drv_a(0, 1, 5'd9, 32'h12345678, 5'd9, 5'd9);
    push(0, 0, 0, 64'h12345678, 7);
    push(0, 0, 1, 64'h12345678, 7);
    drv_a(0, 0, 5'd0, 32'd0, 5'd9, 5'd9);

    // Hardwired zero register
    push(0, 0, 0, 64'd0, 8);
    push(0, 0, 1, 64'd0, 8);
    drv_a(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    push(0, 0, 0, 64'd0, 9);
    push(0, 0, 1, 64'd0, 9);
    drv_a(0, 0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Reset mid-sweep with a simultaneous write, then a write during CLEAR
    drv_a(0, 1, 5'd5, 32'h77, 5'd0, 5'd0);
    push(0, 0, 0, 64'h77, 10);
    drv_a(0, 0, 5'd0, 32'd0, 5'd5, 5'd0);
    push(0, 1, 0, 64'd0, 11);
    drv_a(1, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int k = 1; k <= 10; k++) begin
      push(0, 1, 0, 64'd0, 11);
      drv_a(0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    end
    push(0, 1, 0, 64'd0, 12);
    drv_a(1, 1, 5'd5, 32'hAA, 5'd0, 5'd0);
    for (int k = 1; k <= 32; k++) begin
      push(0, 1, 0, 64'(k == 32), 12);
      drv_a(0, (k == 20), 5'd5, 32'h55, 5'd0, 5'd0);
    end
    push(0, 0, 0, 64'd0, 13);
    push(0, 0, 1, 64'd0, 13);
    drv_a(0, 0, 5'd0, 32'd0, 5'd5, 5'd5);
    drv_a(0, 1, 5'd5, 32'h1234, 5'd0, 5'd0);
    push(0, 0, 0, 64'h1234, 14);
    push(0, 0, 1, 64'd0, 14);
    drv_a(0, 0, 5'd0, 32'd0, 5'd5, 5'd6);

    // DUT B: zero register disabled
    sweep_b(20);
    push(1, 0, 0, 64'hFFFFFFFF, 21);
    push(1, 0, 1, 64'hFFFFFFFF, 21);
    drv_b(0, 1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    push(1, 0, 0, 64'hFFFFFFFF, 22);
    push(1, 0, 1, 64'hFFFFFFFF, 22);
    drv_b(0, 0, 5'd0, 32'd0, 5'd0, 5'd0);

    // DUT C: four 64-bit ports, 16 entries
    cval[1] = 64'h0123456789ABCDEF;
    cval[2] = 64'hFEDCBA9876543210;
    cval[3] = 64'hDEADBEEFCAFEF00D;
    cval[4] = 64'h0000000100000002;
    sweep_c(30);
    for (int i = 1; i <= 4; i++)
      drv_c(0, 1, 4'(i), cval[i], 4'd0, 4'd0, 4'd0, 4'd0);
    for (int p = 0; p < 4; p++) push(2, 0, p, cval[p+1], 31);
    drv_c(0, 0, 4'd0, 64'd0, 4'd1, 4'd2, 4'd3, 4'd4);
    for (int p = 0; p < 4; p++) push(2, 0, p, cval[4-p], 32);
    drv_c(0, 0, 4'd0, 64'd0, 4'd4, 4'd3, 4'd2, 4'd1);

    drv_a(0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    drv_a(0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
